// File: rtl/dma.sv
// dma: single-channel word copy engine with a four-register CPU port and a bus initiator port.
// Defining DMA_FILL_EN adds fill mode, where the full 32-bit SRC value is written as the pattern.
module dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  output logic        m_stb,
  output logic        m_we,
  output logic [21:0] m_addr,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  input  logic        m_ack
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state;
  logic [31:0] src;
  logic [21:0] dst;
  logic [15:0] cnt;
  logic        ien;
  logic        done;
  logic        aborted;
  logic        abort_pend;
  logic        fill_mode;
  logic        reg_wr;
  logic        busy;
  logic        start_fill;
  logic [31:0] src_wr;
  logic [21:0] src_next;

  assign reg_wr   = stb & we;
  assign busy     = (state != IDLE);
  assign ack      = stb;
  assign src_next = src[23:2] + 22'd1;

`ifdef DMA_FILL_EN
  assign src_wr     = data_in;
  assign start_fill = data_in[4];
`else
  assign src_wr     = {8'h00, data_in[23:2], 2'b00};
  assign start_fill = 1'b0;
  assign fill_mode  = 1'b0;
  logic unused_data;
  assign unused_data = ^data_in[31:24];
`endif

  always_comb begin
    data_out = 32'd0;
    case (addr)
      2'd0:    data_out = src;
      2'd1:    data_out = {8'h00, dst, 2'b00};
      2'd2:    data_out = {16'h0000, cnt};
      default: data_out = {27'd0, fill_mode, aborted, ien, done, busy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= 32'd0;
      dst        <= 22'd0;
      cnt        <= 16'd0;
      ien        <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      irq        <= 1'b0;
      m_stb      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 22'd0;
      m_dout     <= 32'd0;
`ifdef DMA_FILL_EN
      fill_mode  <= 1'b0;
`endif
    end else begin
      irq <= done & ien;

      // CPU register writes; the bus-side updates below come later so a completing
      // transfer's done wins over a simultaneous clear.
      if (reg_wr) begin
        case (addr)
          2'd0: if (!busy) src <= src_wr;
          2'd1: if (!busy) dst <= data_in[23:2];
          2'd2: if (!busy) cnt <= data_in[15:0];
          default: begin
            ien <= data_in[2];
            if (data_in[3]) begin
              done    <= 1'b0;
              aborted <= 1'b0;
            end
            if (busy && data_in[1]) abort_pend <= 1'b1;
`ifdef DMA_FILL_EN
            if (!busy) fill_mode <= data_in[4];
`endif
            if (!busy && data_in[0]) begin
              if (cnt == 16'd0) begin
                done <= 1'b1;
              end else begin
                m_stb <= 1'b1;
                if (start_fill) begin
                  state  <= WR;
                  m_we   <= 1'b1;
                  m_addr <= dst;
                  m_dout <= src;
                end else begin
                  state  <= RD;
                  m_we   <= 1'b0;
                  m_addr <= src[23:2];
                end
              end
            end
          end
        endcase
      end

      // Initiator side: strobe and address stay put until m_ack is sampled.
      case (state)
        RD: if (m_ack) begin
          if (abort_pend) begin
            state      <= IDLE;
            m_stb      <= 1'b0;
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
          end else begin
            state  <= WR;
            m_we   <= 1'b1;
            m_addr <= dst;
            m_dout <= m_din;
          end
        end
        WR: if (m_ack) begin
          dst <= dst + 22'd1;
          cnt <= cnt - 16'd1;
          if (!fill_mode) src[23:2] <= src_next;
          if (cnt == 16'd1 || abort_pend) begin
            state      <= IDLE;
            m_stb      <= 1'b0;
            m_we       <= 1'b0;
            abort_pend <= 1'b0;
            if (cnt == 16'd1) done <= 1'b1;
            else              aborted <= 1'b1;
          end else if (fill_mode) begin
            m_addr <= dst + 22'd1;
          end else begin
            state  <= RD;
            m_we   <= 1'b0;
            m_addr <= src_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
